// File: rtl/llbit_reservation_table_pkg.sv
// Shared encodings and defaults for the ll/sc reservation table.
// Timed expiry of reservations is enabled by defining LL_TIMEOUT_EN.
package llbit_reservation_table_pkg;

    localparam int unsigned LlGranLsb = 2;

    typedef enum logic {
        LlZero  = 1'b0,
        LlValid = 1'b1
    } llbit_e;

    // Channel-id width; a single-channel table still carries a 1-bit tid.
    function automatic int unsigned ll_tid_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/llbit_reservation_table_entry.sv
// One channel's link reservation: valid bit, granule address and, with LL_TIMEOUT_EN,
// an expiry counter. Clear/set/snoop inputs arrive already decoded from the top level.
module llbit_entry
    import llbit_reservation_table_pkg::*;
#(
`ifdef LL_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8,
`endif
    parameter int unsigned GRAN_W  = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              excpt_clr,
    input  logic              ll_set,
    input  logic [GRAN_W-1:0] ll_gran,
    input  logic              sc_clr,
    input  logic              snoop_hit,
    output logic              valid,
    output logic [GRAN_W-1:0] gran
);

    llbit_e            valid_q, valid_d;
    logic [GRAN_W-1:0] gran_q;
`ifdef LL_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    always_comb begin
        valid_d = valid_q;
`ifdef LL_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (excpt_clr) begin
            valid_d = LlZero;
        end else if (ll_set) begin
            valid_d = LlValid;
`ifdef LL_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else if (sc_clr || snoop_hit) begin
            valid_d = LlZero;
`ifdef LL_TIMEOUT_EN
        end else if (valid_q == LlValid) begin
            // Last live cycle is when the counter reads TIMEOUT-1.
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                valid_d = LlZero;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= LlZero;
`ifdef LL_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
`ifdef LL_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Address is only meaningful while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ll_set) begin
            gran_q <= ll_gran;
        end
    end

    assign valid = (valid_q == LlValid);
    assign gran  = gran_q;

endmodule

// File: rtl/llbit_reservation_table.sv
// Per-channel ll/sc link reservation table: tid decode, granule compare, sc_ok and rllbit.
// Define LL_TIMEOUT_EN to make reservations expire TIMEOUT cycles after the ll.
module llbit_reservation_table
    import llbit_reservation_table_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned GRAN_LSB = LlGranLsb,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned TidW    = ll_tid_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ll_valid,
    input  logic [TidW-1:0]   ll_tid,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_valid,
    input  logic [TidW-1:0]   sc_tid,
    input  logic [ADDR_W-1:0] sc_addr,
    output logic              sc_ok,
    input  logic              st_valid,
    input  logic [TidW-1:0]   st_tid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic              excpt,
    input  logic [TidW-1:0]   excpt_tid,
    output logic [NUM_CH-1:0] rllbit
);

    localparam int unsigned GranW = ADDR_W - GRAN_LSB;

    if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << CNT_W) || GRAN_LSB >= ADDR_W) begin : g_param_err
        $error("llbit_reservation_table: bad TIMEOUT/CNT_W/GRAN_LSB");
    end

    logic [NUM_CH-1:0] ll_hit, sc_hit, st_hit, ex_hit, valid, snoop_hit;
    logic [GranW-1:0]  gran [NUM_CH];
    logic              st_tid_ok;
    logic              unused_addr_lsbs;

    // A tid with no matching channel decodes to all-zero and is thereby ignored.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ll_hit[i] = ll_valid && (ll_tid == TidW'(i));
            sc_hit[i] = sc_valid && (sc_tid == TidW'(i));
            st_hit[i] = st_valid && (st_tid == TidW'(i));
            ex_hit[i] = excpt && (excpt_tid == TidW'(i));
        end
        st_tid_ok = |st_hit;
    end

    always_comb begin
        sc_ok = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sc_hit[i] && valid[i] && (gran[i] == sc_addr[ADDR_W-1:GRAN_LSB])) begin
                sc_ok = 1'b1;
            end
        end
        if (rst) begin
            sc_ok = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_entry
        logic st_snoop, sc_snoop;

        // A successful sc behaves as a store towards every other channel.
        assign st_snoop = st_tid_ok && !st_hit[i] && (gran[i] == st_addr[ADDR_W-1:GRAN_LSB]);
        assign sc_snoop = sc_ok && !sc_hit[i] && (gran[i] == sc_addr[ADDR_W-1:GRAN_LSB]);
        assign snoop_hit[i] = valid[i] && (st_snoop || sc_snoop);

        llbit_entry #(
`ifdef LL_TIMEOUT_EN
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W),
`endif
            .GRAN_W  (GranW)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .excpt_clr (ex_hit[i]),
            .ll_set    (ll_hit[i]),
            .ll_gran   (ll_addr[ADDR_W-1:GRAN_LSB]),
            .sc_clr    (sc_hit[i]),
            .snoop_hit (snoop_hit[i]),
            .valid     (valid[i]),
            .gran      (gran[i])
        );
    end

    assign rllbit = valid;

    // Sub-granule address bits take no part in matching.
    assign unused_addr_lsbs = ^{ll_addr, sc_addr, st_addr};

endmodule

// File: tb/tb_llbit_reservation_table.sv
// Directed self-checking bench for llbit_reservation_table (2 channels, word granule).
module tb_llbit_reservation_table;

    localparam int unsigned NumCh = 2;
    localparam int unsigned AddrW = 32;
`ifdef LL_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ll_valid, sc_valid, st_valid, excpt;
    logic [0:0]       ll_tid, sc_tid, st_tid, excpt_tid;
    logic [AddrW-1:0] ll_addr, sc_addr, st_addr;
    logic             sc_ok;
    logic [NumCh-1:0] rllbit;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    llbit_reservation_table #(
        .NUM_CH   (NumCh),
        .ADDR_W   (AddrW),
        .GRAN_LSB (2),
        .TIMEOUT  (4),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ll_valid  (ll_valid),
        .ll_tid    (ll_tid),
        .ll_addr   (ll_addr),
        .sc_valid  (sc_valid),
        .sc_tid    (sc_tid),
        .sc_addr   (sc_addr),
        .sc_ok     (sc_ok),
        .st_valid  (st_valid),
        .st_tid    (st_tid),
        .st_addr   (st_addr),
        .excpt     (excpt),
        .excpt_tid (excpt_tid),
        .rllbit    (rllbit)
    );

    task automatic idle();
        rst = 1'b0;
        ll_valid = 1'b0; ll_tid = '0; ll_addr = '0;
        sc_valid = 1'b0; sc_tid = '0; sc_addr = '0;
        st_valid = 1'b0; st_tid = '0; st_addr = '0;
        excpt = 1'b0; excpt_tid = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic chk_rll(input string name, input logic [NumCh-1:0] exp);
        n_asserts++;
        if (rllbit !== exp) begin
            n_fail++;
            $display("FAIL %s: rllbit=%b expected %b", name, rllbit, exp);
        end
    endtask

    task automatic chk_ok(input string name, input logic exp);
        n_asserts++;
        if (sc_ok !== exp) begin
            n_fail++;
            $display("FAIL %s: sc_ok=%b expected %b", name, sc_ok, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h0;
        #1;
        chk_ok("reset_sc_ok", 1'b0);
        cycle();
        chk_rll("reset_rllbit", 2'b00);
        idle();
    endtask

    task automatic test_ll_sc();
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h100;
        cycle();
        idle();
        chk_rll("ll_set_visible", 2'b01);
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h100;
        #1;
        chk_ok("ll_sc_ok", 1'b1);
        cycle();
        idle();
        chk_rll("sc_clears_own", 2'b00);
    endtask

    task automatic test_store_snoop();
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h100;
        cycle();
        idle();
        st_valid = 1'b1; st_tid = 1'b1; st_addr = 32'h102;
        cycle();
        idle();
        chk_rll("store_same_word_breaks", 2'b00);
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h100;
        #1;
        chk_ok("sc_after_store_hit", 1'b0);
        cycle();
        idle();

        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h100;
        cycle();
        idle();
        st_valid = 1'b1; st_tid = 1'b1; st_addr = 32'h104;
        cycle();
        idle();
        chk_rll("store_next_word_keeps", 2'b01);
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h100;
        #1;
        chk_ok("sc_after_store_miss", 1'b1);
        cycle();
        idle();
    endtask

    task automatic test_sc_as_store();
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h200;
        cycle();
        ll_tid = 1'b1;
        cycle();
        idle();
        chk_rll("both_linked", 2'b11);
        sc_valid = 1'b1; sc_tid = 1'b1; sc_addr = 32'h200;
        #1;
        chk_ok("sc_ch1_ok", 1'b1);
        cycle();
        idle();
        chk_rll("sc_breaks_other", 2'b00);
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h200;
        #1;
        chk_ok("sc_ch0_after_break", 1'b0);
        cycle();
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b1; ll_addr = 32'h300;
        excpt = 1'b1; excpt_tid = 1'b1;
        cycle();
        idle();
        chk_rll("excpt_beats_ll", 2'b00);
        ll_valid = 1'b1; ll_tid = 1'b1; ll_addr = 32'h300;
        st_valid = 1'b1; st_tid = 1'b0; st_addr = 32'h300;
        cycle();
        idle();
        chk_rll("ll_beats_store", 2'b10);
        st_valid = 1'b1; st_tid = 1'b1; st_addr = 32'h300;
        cycle();
        idle();
        chk_rll("own_store_keeps", 2'b10);
        ll_valid = 1'b1; ll_tid = 1'b1; ll_addr = 32'h400;
        sc_valid = 1'b1; sc_tid = 1'b1; sc_addr = 32'h300;
        #1;
        chk_ok("ll_sc_same_cycle_ok", 1'b1);
        cycle();
        idle();
        chk_rll("ll_beats_sc", 2'b10);
        sc_valid = 1'b1; sc_tid = 1'b1; sc_addr = 32'h300;
        #1;
        chk_ok("sc_old_addr_after_relink", 1'b0);
        cycle();
        idle();
        chk_rll("failed_sc_clears", 2'b00);
    endtask

    task automatic test_reset_mid();
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h600;
        cycle();
        idle();
        chk_rll("mid_ll_set", 2'b01);
        rst = 1'b1;
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h600;
        #1;
        chk_ok("sc_ok_forced_in_rst", 1'b0);
        cycle();
        idle();
        chk_rll("mid_rst_clears", 2'b00);
        sc_valid = 1'b1; sc_tid = 1'b0; sc_addr = 32'h600;
        #1;
        chk_ok("sc_after_mid_rst", 1'b0);
        cycle();
        idle();
    endtask

    task automatic test_timeout();
        logic [NumCh-1:0] exp;
        do_reset();
        ll_valid = 1'b1; ll_tid = 1'b0; ll_addr = 32'h700;
        cycle();
        idle();
        for (int c = 1; c <= 100; c++) begin
            if (c <= 6 || c == 100) begin
                exp = (TimeoutEn && c > 4) ? 2'b00 : 2'b01;
                chk_rll($sformatf("timeout_cycle_%0d", c), exp);
            end
            cycle();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_ll_sc();
        test_store_snoop();
        test_sc_as_store();
        test_priority();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
